// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage, forwarding unit and decoder:
// ALU op codes, forwarding select codes and default datapath widths.
package ex_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_REG_AW = 3;

    typedef enum logic [2:0] {
        AluAdd  = 3'b000,
        AluSub  = 3'b001,
        AluAnd  = 3'b010,
        AluOr   = 3'b011,
        AluXor  = 3'b100,
        AluShl  = 3'b101,
        AluShr  = 3'b110,
        AluPass = 3'b111
    } alu_op_e;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    function automatic logic op_sets_carry(input logic [2:0] op);
        return (op == AluAdd) || (op == AluSub);
    endfunction

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU for the execute stage. ADD/SUB run one bit wider so the
// top bit is the carry (for SUB: 1 means no borrow, i.e. a >= b unsigned).
module ex_alu
    import ex_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_DATA_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] wide;

    always_comb begin
        wide   = '0;
        result = '0;
        carry  = 1'b0;
        unique case (alu_op_e'(op))
            AluAdd: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[WIDTH-1:0];
                carry  = wide[WIDTH];
            end
            AluSub: begin
                // Two's-complement subtract so the top bit reads as "no borrow".
                wide   = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                result = wide[WIDTH-1:0];
                carry  = wide[WIDTH];
            end
            AluAnd:  result = a & b;
            AluOr:   result = a | b;
            AluXor:  result = a ^ b;
            AluShl:  result = a << b[2:0];
            AluShr:  result = a >> b[2:0];
            AluPass: result = b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding muxes, immediate mux, ALU and the EX/MEM pipeline
// register with status flags. Stall, flush or an invalid slot inserts a bubble.
module ex_stage
    import ex_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] idExR1Data,
    input  logic [DATA_W-1:0] idExR2Data,
    input  logic [DATA_W-1:0] idExImm,
    input  logic              idExAluSrcB,
    input  logic [2:0]        idExAluOp,
    input  logic [REG_AW-1:0] idExDest,
    input  logic              idExRegWrite,
    input  logic              idExMemWrite,
    input  logic              idExRegWriteDataSel,
    input  logic              idExValid,
    input  logic [1:0]        aluInputAForwardingSel,
    input  logic [1:0]        aluInputBForwardingSel,
    input  logic [DATA_W-1:0] memWbWriteData,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] exMemAluResult,
    output logic [DATA_W-1:0] exMemStoreData,
    output logic [REG_AW-1:0] exMemDest,
    output logic              exMemRegWrite,
    output logic              exMemMemWrite,
    output logic              exMemRegWriteDataSel,
    output logic              exMemValid,
    output logic              carryFlag,
    output logic              zeroFlag
);

    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              bubble;

    logic [DATA_W-1:0] result_q;
    logic [DATA_W-1:0] store_q;
    logic [REG_AW-1:0] dest_q;
    logic              reg_write_q;
    logic              mem_write_q;
    logic              data_sel_q;
    logic              valid_q;
    logic              carry_q;
    logic              zero_q;

    // The EX/MEM path is taken straight from the output register: no bypass stage.
    always_comb begin
        fwd_a = idExR1Data;
        unique case (aluInputAForwardingSel)
            FWD_EXMEM: fwd_a = result_q;
            FWD_MEMWB: fwd_a = memWbWriteData;
            default:   fwd_a = idExR1Data;
        endcase
    end

    always_comb begin
        fwd_b = idExR2Data;
        unique case (aluInputBForwardingSel)
            FWD_EXMEM: fwd_b = result_q;
            FWD_MEMWB: fwd_b = memWbWriteData;
            default:   fwd_b = idExR2Data;
        endcase
    end

    assign alu_b  = idExAluSrcB ? idExImm : fwd_b;
    assign bubble = flush || stall || !idExValid;

    ex_alu #(
        .WIDTH(DATA_W)
    ) u_alu (
        .a     (fwd_a),
        .b     (alu_b),
        .op    (idExAluOp),
        .result(alu_result),
        .carry (alu_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q    <= '0;
            store_q     <= '0;
            dest_q      <= '0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            data_sel_q  <= 1'b1;
            valid_q     <= 1'b0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
        end else if (bubble) begin
            // Data, dest and flags hold; the stale result is never forwarded since regWrite=0.
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            data_sel_q  <= 1'b1;
            valid_q     <= 1'b0;
        end else begin
            result_q    <= alu_result;
            store_q     <= fwd_b;
            dest_q      <= idExDest;
            reg_write_q <= idExRegWrite;
            mem_write_q <= idExMemWrite;
            data_sel_q  <= idExRegWriteDataSel;
            valid_q     <= 1'b1;
            zero_q      <= (alu_result == '0);
            if (op_sets_carry(idExAluOp)) begin
                carry_q <= alu_carry;
            end
        end
    end

    assign exMemAluResult       = result_q;
    assign exMemStoreData       = store_q;
    assign exMemDest            = dest_q;
    assign exMemRegWrite        = reg_write_q;
    assign exMemMemWrite        = mem_write_q;
    assign exMemRegWriteDataSel = data_sel_q;
    assign exMemValid           = valid_q;
    assign carryFlag            = carry_q;
    assign zeroFlag             = zero_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: an arithmetic reference model checked on every
// falling edge, plus hand-computed literal checks of the directed scenarios.
module tb_ex_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] idExR1Data, idExR2Data, idExImm, memWbWriteData;
    logic       idExAluSrcB;
    logic [2:0] idExAluOp;
    logic [2:0] idExDest;
    logic       idExRegWrite, idExMemWrite, idExRegWriteDataSel, idExValid;
    logic [1:0] aluInputAForwardingSel, aluInputBForwardingSel;
    logic       stall, flush;
    logic [7:0] exMemAluResult, exMemStoreData;
    logic [2:0] exMemDest;
    logic       exMemRegWrite, exMemMemWrite, exMemRegWriteDataSel, exMemValid;
    logic       carryFlag, zeroFlag;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    ex_stage dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .idExR1Data            (idExR1Data),
        .idExR2Data            (idExR2Data),
        .idExImm               (idExImm),
        .idExAluSrcB           (idExAluSrcB),
        .idExAluOp             (idExAluOp),
        .idExDest              (idExDest),
        .idExRegWrite          (idExRegWrite),
        .idExMemWrite          (idExMemWrite),
        .idExRegWriteDataSel   (idExRegWriteDataSel),
        .idExValid             (idExValid),
        .aluInputAForwardingSel(aluInputAForwardingSel),
        .aluInputBForwardingSel(aluInputBForwardingSel),
        .memWbWriteData        (memWbWriteData),
        .stall                 (stall),
        .flush                 (flush),
        .exMemAluResult        (exMemAluResult),
        .exMemStoreData        (exMemStoreData),
        .exMemDest             (exMemDest),
        .exMemRegWrite         (exMemRegWrite),
        .exMemMemWrite         (exMemMemWrite),
        .exMemRegWriteDataSel  (exMemRegWriteDataSel),
        .exMemValid            (exMemValid),
        .carryFlag             (carryFlag),
        .zeroFlag              (zeroFlag)
    );

    always #5 clk = ~clk;

    // Reference model state: what the EX/MEM register must hold.
    int m_res, m_store, m_dest, m_carry, m_zero;
    bit m_rw, m_mw, m_ds, m_valid;

    always @(posedge clk) begin
        int a, b, bop, r;
        if (!rst_n) begin
            m_res = 0; m_store = 0; m_dest = 0; m_carry = 0; m_zero = 0;
            m_rw = 0; m_mw = 0; m_ds = 1; m_valid = 0;
        end else if (flush || stall || !idExValid) begin
            m_rw = 0; m_mw = 0; m_ds = 1; m_valid = 0;
        end else begin
            a = (aluInputAForwardingSel == 2'd1) ? m_res :
                (aluInputAForwardingSel == 2'd2) ? int'(memWbWriteData) : int'(idExR1Data);
            b = (aluInputBForwardingSel == 2'd1) ? m_res :
                (aluInputBForwardingSel == 2'd2) ? int'(memWbWriteData) : int'(idExR2Data);
            bop = idExAluSrcB ? int'(idExImm) : b;
            case (idExAluOp)
                3'd0: begin r = a + bop; m_carry = (r > 255) ? 1 : 0; end
                3'd1: begin r = a - bop; m_carry = (a >= bop) ? 1 : 0; end
                3'd2: r = a & bop;
                3'd3: r = a | bop;
                3'd4: r = a ^ bop;
                3'd5: r = a * (1 << (bop % 8));
                3'd6: r = a / (1 << (bop % 8));
                default: r = bop;
            endcase
            r = r & 255;
            m_res = r; m_store = b; m_dest = int'(idExDest);
            m_zero = (r == 0) ? 1 : 0;
            m_rw = idExRegWrite; m_mw = idExMemWrite; m_ds = idExRegWriteDataSel; m_valid = 1;
        end
    end

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("m_result", int'(exMemAluResult), m_res);
            cmp("m_store", int'(exMemStoreData), m_store);
            cmp("m_dest", int'(exMemDest), m_dest);
            cmp("m_regwrite", int'(exMemRegWrite), int'(m_rw));
            cmp("m_memwrite", int'(exMemMemWrite), int'(m_mw));
            cmp("m_datasel", int'(exMemRegWriteDataSel), int'(m_ds));
            cmp("m_valid", int'(exMemValid), int'(m_valid));
            cmp("m_carry", int'(carryFlag), m_carry);
            cmp("m_zero", int'(zeroFlag), m_zero);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic nop();
        idExR1Data = 8'h00; idExR2Data = 8'h00; idExImm = 8'h00; memWbWriteData = 8'h00;
        idExAluSrcB = 0; idExAluOp = 3'd0; idExDest = 3'd0;
        idExRegWrite = 0; idExMemWrite = 0; idExRegWriteDataSel = 1; idExValid = 0;
        aluInputAForwardingSel = 2'd0; aluInputBForwardingSel = 2'd0;
        stall = 0; flush = 0;
    endtask

    task automatic instr(input logic [2:0] op, input logic [7:0] r1, input logic [7:0] r2,
                         input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] dest);
        nop();
        idExAluOp = op; idExR1Data = r1; idExR2Data = r2;
        aluInputAForwardingSel = sa; aluInputBForwardingSel = sb;
        idExDest = dest; idExRegWrite = 1; idExValid = 1;
    endtask

    initial begin
        nop();
        // Reset with random inputs.
        rst_n = 0;
        idExR1Data = 8'($urandom); idExR2Data = 8'($urandom); idExAluOp = 3'($urandom);
        idExValid = 1; idExRegWrite = 1; idExMemWrite = 1; idExRegWriteDataSel = 0;
        memWbWriteData = 8'($urandom);
        step();
        chk_en = 1;
        step();
        cmp("rst_result", int'(exMemAluResult), 0);
        cmp("rst_datasel", int'(exMemRegWriteDataSel), 1);
        cmp("rst_valid", int'(exMemValid), 0);
        cmp("rst_memwrite", int'(exMemMemWrite), 0);
        rst_n = 1;

        // Plain ADD.
        instr(3'd0, 8'h7F, 8'h01, 2'd0, 2'd0, 3'd3);
        step();
        cmp("add_result", int'(exMemAluResult), 8'h80);
        cmp("add_carry", int'(carryFlag), 0);
        cmp("add_zero", int'(zeroFlag), 0);
        cmp("add_dest", int'(exMemDest), 3);

        // ADD with carry out, then SUB forwarding A from EX/MEM.
        instr(3'd0, 8'hFF, 8'h01, 2'd0, 2'd0, 3'd4);
        step();
        cmp("addc_result", int'(exMemAluResult), 8'h00);
        cmp("addc_carry", int'(carryFlag), 1);
        cmp("addc_zero", int'(zeroFlag), 1);
        instr(3'd1, 8'hAA, 8'h05, 2'd1, 2'd0, 3'd5);
        step();
        cmp("subfwd_result", int'(exMemAluResult), 8'hFB);
        cmp("subfwd_carry", int'(carryFlag), 0);

        // OR with immediate; store data comes from the MEM/WB-forwarded B.
        instr(3'd3, 8'h10, 8'h99, 2'd0, 2'd2, 3'd6);
        memWbWriteData = 8'h33; idExAluSrcB = 1; idExImm = 8'h04; idExMemWrite = 1;
        step();
        cmp("orimm_result", int'(exMemAluResult), 8'h14);
        cmp("orimm_store", int'(exMemStoreData), 8'h33);
        cmp("orimm_memwrite", int'(exMemMemWrite), 1);

        // Load-use stall for one cycle, then the held instruction completes.
        instr(3'd0, 8'h00, 8'h01, 2'd1, 2'd0, 3'd2);
        stall = 1;
        step();
        cmp("stall_regwrite", int'(exMemRegWrite), 0);
        cmp("stall_valid", int'(exMemValid), 0);
        cmp("stall_result_hold", int'(exMemAluResult), 8'h14);
        cmp("stall_zero_hold", int'(zeroFlag), 0);
        stall = 0;
        step();
        cmp("afterstall_result", int'(exMemAluResult), 8'h15);
        cmp("afterstall_valid", int'(exMemValid), 1);

        // Other ops: SHL, SHR, XOR, AND, PASS, invalid slot.
        instr(3'd5, 8'h81, 8'h0B, 2'd0, 2'd0, 3'd1);
        step();
        cmp("shl_result", int'(exMemAluResult), 8'h08);
        instr(3'd6, 8'h81, 8'h0F, 2'd0, 2'd0, 3'd1);
        step();
        cmp("shr_result", int'(exMemAluResult), 8'h01);
        instr(3'd1, 8'h05, 8'h05, 2'd0, 2'd0, 3'd1);
        step();
        cmp("sub_eq_carry", int'(carryFlag), 1);
        cmp("sub_eq_zero", int'(zeroFlag), 1);
        instr(3'd4, 8'hF0, 8'hFF, 2'd0, 2'd0, 3'd1);
        step();
        cmp("xor_result", int'(exMemAluResult), 8'h0F);
        cmp("xor_carry_hold", int'(carryFlag), 1);
        instr(3'd7, 8'h12, 8'h00, 2'd0, 2'd0, 3'd7);
        step();
        cmp("pass_zero", int'(zeroFlag), 1);
        instr(3'd2, 8'hFF, 8'h3C, 2'd0, 2'd0, 3'd2);
        idExValid = 0;
        step();
        cmp("invalid_valid", int'(exMemValid), 0);

        // Random mix, checked by the model only.
        for (int i = 0; i < 60; i++) begin
            instr(3'($urandom), 8'($urandom), 8'($urandom), 2'($urandom), 2'($urandom),
                  3'($urandom));
            idExImm = 8'($urandom); idExAluSrcB = 1'($urandom);
            memWbWriteData = 8'($urandom); idExMemWrite = 1'($urandom);
            idExRegWriteDataSel = 1'($urandom); idExRegWrite = 1'($urandom);
            stall = ($urandom_range(0, 7) == 0); flush = ($urandom_range(0, 7) == 0);
            idExValid = ($urandom_range(0, 5) != 0);
            step();
        end

        // Flush and stall together, then reset with both still asserted.
        instr(3'd0, 8'h01, 8'h01, 2'd0, 2'd0, 3'd5);
        step();
        cmp("pre_flush_result", int'(exMemAluResult), 8'h02);
        instr(3'd0, 8'h40, 8'h40, 2'd0, 2'd0, 3'd6);
        stall = 1; flush = 1;
        step();
        cmp("flushstall_valid", int'(exMemValid), 0);
        cmp("flushstall_result", int'(exMemAluResult), 8'h02);
        cmp("flushstall_dest", int'(exMemDest), 5);
        rst_n = 0;
        step();
        cmp("midrst_result", int'(exMemAluResult), 0);
        cmp("midrst_dest", int'(exMemDest), 0);
        cmp("midrst_datasel", int'(exMemRegWriteDataSel), 1);
        rst_n = 1;
        instr(3'd0, 8'h20, 8'h03, 2'd0, 2'd0, 3'd7);
        step();
        cmp("postrst_result", int'(exMemAluResult), 8'h23);
        cmp("postrst_valid", int'(exMemValid), 1);
        nop();
        step();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 8-register pipelined datapath, directly downstream of the forwarding unit. It takes the ID/EX operands and the two forwarding selects, resolves each ALU input from the register file, EX/MEM or MEM/WB, executes one ALU operation, and registers the result plus control into the EX/MEM pipeline register. The registered EX/MEM fields feed back to the forwarding unit and the memory stage. On stall or flush the stage inserts a bubble.

## Interface
- DATA_W, 8, datapath width
- REG_AW, 3, register address width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- idExR1Data, idExR2Data  in  DATA_W  register-file operands A/B
- idExImm  in  DATA_W  sign-extended immediate
- idExAluSrcB  in  1  1 = ALU B is immediate
- idExAluOp  in  3  ALU operation
- idExDest  in  REG_AW  destination register
- idExRegWrite, idExMemWrite, idExRegWriteDataSel  in  1  control carried to EX/MEM (DataSel 0 = load, 1 = ALU)
- idExValid  in  1  ID/EX holds a real instruction
- aluInputAForwardingSel, aluInputBForwardingSel  in  2  00 register, 01 EX/MEM, 10 MEM/WB, 11 register
- memWbWriteData  in  DATA_W  MEM/WB writeback value
- stall  in  1  load-use stall from forwarding unit
- flush  in  1  taken-branch squash
- exMemAluResult, exMemStoreData  out  DATA_W  registered result / store data
- exMemDest  out  REG_AW
- exMemRegWrite, exMemMemWrite, exMemRegWriteDataSel, exMemValid  out  1
- carryFlag, zeroFlag  out  1  registered status flags

## Operation
- Forwarded A = mux(aluInputAForwardingSel: idExR1Data, exMemAluResult, memWbWriteData, idExR1Data); B likewise with idExR2Data.
- ALU B = idExImm if idExAluSrcB else forwarded B. Store data = forwarded B (never the immediate).
- aluOp: 000 ADD, 001 SUB (A−B), 010 AND, 011 OR, 100 XOR, 101 SHL A by B[2:0], 110 SHR logical A by B[2:0], 111 PASS B.
- ADD/SUB computed at DATA_W+1 bits; carry = bit DATA_W (SUB: 1 = no borrow, i.e. A ≥ B unsigned). Result truncated to DATA_W.
- Per-cycle update priority: rst_n low > flush > stall > normal.
  - Reset: all outputs 0 (exMemRegWriteDataSel 1, so no load-use stall out of reset).
  - Flush or stall: bubble — exMemValid, exMemRegWrite, exMemMemWrite ← 0, exMemRegWriteDataSel ← 1; data/dest fields hold; flags hold.
  - Normal with idExValid=1: all EX/MEM fields load; zeroFlag ← (result == 0) for every op; carryFlag updates only on ADD/SUB, otherwise holds.
  - Normal with idExValid=0: same as bubble.
- The stage does not hold ID/EX; upstream freezes ID/EX while stall is high. Because the bubble clears exMemRegWrite, the forwarding unit's stall drops the next cycle, so every load-use stall lasts exactly one cycle.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on exMem* after edge N.
- Forwarding path is combinational from exMemAluResult/memWbWriteData through the mux into the ALU, with no internal bypass register.
- stall and flush in the same cycle: one bubble is inserted, identical to flush alone.
- rst_n low mid-stream: outputs clear at the next edge regardless of stall or flush; the first instruction after release is sampled normally.
- A bubble leaves exMemAluResult unchanged, so the stale value is still legal to forward but is never selected, because regWrite=0.

## Structure
- Shared package ex_pkg: ALU op codes, FWD_REG/FWD_EXMEM/FWD_MEMWB select constants, DATA_W/REG_AW defaults. The forwarding unit and decoder use the same package.
- One sub-module, ex_alu: purely combinational; inputs a, b, op; outputs result and carry.
- The top level holds the forwarding muxes, the immediate mux, and the EX/MEM register with flags.

## Test plan
- Reset: rst_n=0 for 2 cycles with random inputs → all outputs 0, exMemRegWriteDataSel=1.
- Plain ADD: R1=0x7F, R2=0x01, sel 00/00, op 000, dest 3, regWrite 1 → next cycle exMemAluResult=0x80, carry 0, zero 0, exMemDest=3.
- EX/MEM forward: back-to-back ADD 0xFF+0x01 (result 0x00, carry 1, zero 1), then SUB with selA=01 and R2=0x05 → 0x00−0x05=0xFB, carry 0.
- MEM/WB forward plus immediate: selB=10, memWbWriteData=0x33, aluSrcB=1, imm=0x04, op 011, A=0x10 → result 0x14; exMemStoreData=0x33.
- Load-use: stall=1 for one cycle → exMemRegWrite=0, exMemValid=0, flags unchanged; next cycle stall=0 and the held instruction completes with the correct forwarded data.
- Flush and stall together, then rst_n low on the following cycle → single bubble, then all outputs 0.
